// File: rtl/branch_predictor.sv
// Branch target buffer with 2-bit saturating direction counters.
// IF looks the fetch PC up combinationally; MEM writes resolved outcomes
// back on the clock edge. Also keeps saturating update/mispredict counts.

// One BTB entry: valid, partial tag, target and direction counter.
module bp_entry #(
  parameter int ADDR_W = 32,
  parameter int TAG_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [TAG_W-1:0]  upd_tag,
  input  logic              upd_is_jump,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  output logic              valid,
  output logic [TAG_W-1:0]  tag,
  output logic [ADDR_W-1:0] target,
  output logic [1:0]        ctr
);

  logic hit;
  assign hit = valid & (tag == upd_tag);

  // Train on a hit; allocate on a taken or jump miss; not-taken misses leave the entry alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid  <= 1'b0;
      tag    <= '0;
      target <= '0;
      ctr    <= 2'b00;
    end else if (wr_en) begin
      if (hit) begin
        if (upd_is_jump) begin
          ctr    <= 2'b11;
          target <= upd_target;
        end else if (upd_taken) begin
          ctr    <= (ctr == 2'b11) ? 2'b11 : ctr + 2'd1;
          target <= upd_target;
        end else begin
          ctr    <= (ctr == 2'b00) ? 2'b00 : ctr - 2'd1;
        end
      end else if (upd_taken || upd_is_jump) begin
        valid  <= 1'b1;
        tag    <= upd_tag;
        target <= upd_target;
        ctr    <= upd_is_jump ? 2'b11 : 2'b10;
      end
    end
  end

endmodule

module branch_predictor #(
  parameter int ADDR_W  = 32,
  parameter int ENTRIES = 16,
  parameter int TAG_W   = 8,
  parameter int CNT_W   = 16,
  localparam int INDEX_W = $clog2(ENTRIES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lookup_valid,
  input  logic [ADDR_W-1:0] lookup_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              update_valid,
  input  logic [ADDR_W-1:0] update_pc,
  input  logic              update_is_jump,
  input  logic              update_taken,
  input  logic [ADDR_W-1:0] update_target,
  input  logic              update_mispredict,
  output logic [CNT_W-1:0]  branch_cnt,
  output logic [CNT_W-1:0]  mispredict_cnt
);

  // pc[1:0] is dropped; index sits just above it, partial tag above the index.
  logic [INDEX_W-1:0] lk_idx, upd_idx;
  logic [TAG_W-1:0]   lk_tag, upd_tag;
  assign lk_idx  = lookup_pc[INDEX_W+1:2];
  assign lk_tag  = lookup_pc[INDEX_W+TAG_W+1:INDEX_W+2];
  assign upd_idx = update_pc[INDEX_W+1:2];
  assign upd_tag = update_pc[INDEX_W+TAG_W+1:INDEX_W+2];

  logic [ENTRIES-1:0]             ent_valid;
  logic [ENTRIES-1:0][TAG_W-1:0]  ent_tag;
  logic [ENTRIES-1:0][ADDR_W-1:0] ent_target;
  logic [ENTRIES-1:0][1:0]        ent_ctr;

  for (genvar i = 0; i < ENTRIES; i++) begin : g_ent
    bp_entry #(.ADDR_W(ADDR_W), .TAG_W(TAG_W)) u_ent (
      .clk         (clk),
      .rst         (rst),
      .wr_en       (update_valid && (upd_idx == INDEX_W'(i))),
      .upd_tag     (upd_tag),
      .upd_is_jump (update_is_jump),
      .upd_taken   (update_taken),
      .upd_target  (update_target),
      .valid       (ent_valid[i]),
      .tag         (ent_tag[i]),
      .target      (ent_target[i]),
      .ctr         (ent_ctr[i])
    );
  end

  // Zero-latency lookup of pre-update contents; reset forces the miss path.
  always_comb begin
    pred_hit    = lookup_valid & ~rst & ent_valid[lk_idx] & (ent_tag[lk_idx] == lk_tag);
    pred_taken  = pred_hit & ent_ctr[lk_idx][1];
    pred_target = pred_taken ? ent_target[lk_idx] : lookup_pc + ADDR_W'(4);
  end

  // Saturating statistics; nothing counts without update_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
    end else if (update_valid) begin
      if (branch_cnt != '1) branch_cnt <= branch_cnt + CNT_W'(1);
      if (update_mispredict && (mispredict_cnt != '1))
        mispredict_cnt <= mispredict_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench: directed scenarios then random traffic, both compared
// against a table-level behavioural model. A second instance with 3-bit
// statistics counters exercises saturation.
module tb_branch_predictor;
  localparam int AW = 32;
  localparam int N  = 16;
  localparam int TW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          lookup_valid = 1'b0;
  logic [AW-1:0] lookup_pc = '0;
  logic          uv = 1'b0, ujump = 1'b0, utaken = 1'b0, umis = 1'b0;
  logic [AW-1:0] upc = '0, utgt = '0;

  logic          pred_hit, pred_taken, hit_s, taken_s;
  logic [AW-1:0] pred_target, tgt_s;
  logic [15:0]   br, mis;
  logic [2:0]    br_s, mis_s;

  branch_predictor #(.ADDR_W(AW), .ENTRIES(N), .TAG_W(TW), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .update_valid(uv), .update_pc(upc), .update_is_jump(ujump),
    .update_taken(utaken), .update_target(utgt), .update_mispredict(umis),
    .branch_cnt(br), .mispredict_cnt(mis));

  branch_predictor #(.ADDR_W(AW), .ENTRIES(N), .TAG_W(TW), .CNT_W(3)) dut_s (
    .clk(clk), .rst(rst), .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .pred_hit(hit_s), .pred_taken(taken_s), .pred_target(tgt_s),
    .update_valid(uv), .update_pc(upc), .update_is_jump(ujump),
    .update_taken(utaken), .update_target(utgt), .update_mispredict(umis),
    .branch_cnt(br_s), .mispredict_cnt(mis_s));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural model: one record per BTB slot plus plain integer counters.
  bit          m_valid [N];
  int unsigned m_tag   [N];
  logic [31:0] m_tgt   [N];
  int          m_ctr   [N];
  int          m_br, m_mis, m_br_s, m_mis_s;

  function automatic int unsigned idx_of(logic [31:0] pc);
    return (pc >> 2) % N;
  endfunction
  function automatic int unsigned tag_of(logic [31:0] pc);
    return (pc >> 6) % (1 << TW);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = '0; m_ctr[i] = 0;
    end
    m_br = 0; m_mis = 0; m_br_s = 0; m_mis_s = 0;
  endtask

  task automatic model_update();
    int unsigned i, t;
    if (rst) begin
      model_reset();
      return;
    end
    if (!uv) return;
    m_br   = (m_br   < 65535) ? m_br + 1   : m_br;
    m_br_s = (m_br_s < 7)     ? m_br_s + 1 : m_br_s;
    if (umis) begin
      m_mis   = (m_mis   < 65535) ? m_mis + 1   : m_mis;
      m_mis_s = (m_mis_s < 7)     ? m_mis_s + 1 : m_mis_s;
    end
    i = idx_of(upc);
    t = tag_of(upc);
    if (m_valid[i] && m_tag[i] == t) begin
      if (ujump) begin
        m_ctr[i] = 3; m_tgt[i] = utgt;
      end else if (utaken) begin
        m_ctr[i] = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1; m_tgt[i] = utgt;
      end else begin
        m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
      end
    end else if (utaken || ujump) begin
      m_valid[i] = 1; m_tag[i] = t; m_tgt[i] = utgt; m_ctr[i] = ujump ? 3 : 2;
    end
  endtask

  task automatic model_check();
    int unsigned i;
    bit          h, tk;
    logic [31:0] tg;
    i  = idx_of(lookup_pc);
    h  = lookup_valid && !rst && m_valid[i] && (m_tag[i] == tag_of(lookup_pc));
    tk = h && (m_ctr[i] >= 2);
    tg = tk ? m_tgt[i] : lookup_pc + 32'd4;
    chk("hit",     64'(pred_hit),    64'(h));
    chk("taken",   64'(pred_taken),  64'(tk));
    chk("target",  64'(pred_target), 64'(tg));
    chk("br_cnt",  64'(br),          64'(m_br));
    chk("mis_cnt", 64'(mis),         64'(m_mis));
    chk("br_s",    64'(br_s),        64'(m_br_s));
    chk("mis_s",   64'(mis_s),       64'(m_mis_s));
  endtask

  // One clock: check combinational outputs mid-cycle, then advance the model.
  task automatic tick();
    @(negedge clk);
    model_check();
    @(posedge clk);
    model_update();
    #1;
  endtask

  // Directed expectation against literal values, between edges.
  task automatic peek(input string tag, input bit h, input bit tk, input logic [31:0] tg);
    #1;
    chk({tag, "_hit"},   64'(pred_hit),    64'(h));
    chk({tag, "_taken"}, 64'(pred_taken),  64'(tk));
    chk({tag, "_tgt"},   64'(pred_target), 64'(tg));
  endtask

  task automatic upd(input bit v, input logic [31:0] pc, input bit j, input bit t,
                     input logic [31:0] tg, input bit m);
    uv = v; upc = pc; ujump = j; utaken = t; utgt = tg; umis = m;
  endtask

  task automatic look(input logic [31:0] pc);
    lookup_valid = 1'b1; lookup_pc = pc;
  endtask

  function automatic logic [31:0] rpc();
    logic [31:0] p;
    p = 32'(($urandom_range(0, 3) << 6) | ($urandom_range(0, N - 1) << 2) | $urandom_range(0, 3));
    if ($urandom_range(0, 15) == 0) p = $urandom;
    return p;
  endfunction

  initial begin
    model_reset();
    // Cold start
    rst = 1'b1; look(32'h40);
    tick(); tick();
    rst = 1'b0;
    peek("cold", 0, 0, 32'h44);
    chk("cold_br", 64'(br), 64'd0);
    chk("cold_mis", 64'(mis), 64'd0);
    tick();

    // Statistics: 9 updates, 5 mispredicts, on a not-taken miss (no table change)
    for (int i = 0; i < 9; i++) begin
      upd(1, 32'h300, 0, 0, 32'h0, i < 5);
      tick();
    end
    upd(0, 32'h300, 0, 0, 32'h0, 0);
    #1;
    chk("sat_br_s", 64'(br_s), 64'd7);
    chk("sat_mis_s", 64'(mis_s), 64'd5);
    chk("sat_br", 64'(br), 64'd9);
    for (int i = 0; i < 3; i++) begin
      upd(1, 32'h300, 0, 0, 32'h0, 1);
      tick();
    end
    upd(0, 32'h300, 0, 0, 32'h0, 1);
    tick();
    #1;
    chk("sat_mis_s_hold", 64'(mis_s), 64'd7);
    chk("mis_novalid", 64'(mis), 64'd8);
    upd(0, 32'h0, 0, 0, 32'h0, 0);
    rst = 1'b1; tick(); rst = 1'b0;

    // Allocate and counter walk at 0x40
    upd(1, 32'h40, 0, 1, 32'h100, 0); tick();
    upd(0, 32'h0, 0, 0, 32'h0, 0); look(32'h40);
    peek("alloc", 1, 1, 32'h100); tick();
    for (int i = 0; i < 2; i++) begin upd(1, 32'h40, 0, 0, 32'h0, 0); tick(); end
    upd(0, 32'h0, 0, 0, 32'h0, 0);
    peek("nt2", 1, 0, 32'h44); tick();
    for (int i = 0; i < 2; i++) begin upd(1, 32'h40, 0, 0, 32'h0, 0); tick(); end
    upd(0, 32'h0, 0, 0, 32'h0, 0);
    peek("nt4", 1, 0, 32'h44); tick();
    upd(1, 32'h40, 0, 1, 32'h100, 0); tick();
    upd(0, 32'h0, 0, 0, 32'h0, 0);
    peek("t1_weak_nt", 1, 0, 32'h44); tick();
    for (int i = 0; i < 2; i++) begin upd(1, 32'h40, 0, 1, 32'h100, 0); tick(); end
    // ctr now 11: one not-taken still predicts taken
    upd(1, 32'h40, 0, 0, 32'h0, 0); tick();
    upd(0, 32'h0, 0, 0, 32'h0, 0);
    peek("strong", 1, 1, 32'h100); tick();

    // Same-cycle hazard: lookup sees old target, next cycle sees new one
    upd(1, 32'h40, 0, 1, 32'h200, 0); look(32'h40);
    peek("hazard_old", 1, 1, 32'h100); tick();
    upd(0, 32'h0, 0, 0, 32'h0, 0);
    peek("hazard_new", 1, 1, 32'h200); tick();

    // Jump and aliasing: 0x80 and 0xC0 share index 0
    upd(1, 32'h80, 1, 0, 32'h400, 0); tick();
    upd(0, 32'h0, 0, 0, 32'h0, 0); look(32'h80);
    peek("jump", 1, 1, 32'h400); tick();
    look(32'hC0);
    peek("alias_miss", 0, 0, 32'hC4); tick();
    upd(1, 32'hC0, 0, 1, 32'h500, 0); tick();
    upd(0, 32'h0, 0, 0, 32'h0, 0); look(32'h80);
    peek("evicted", 0, 0, 32'h84); tick();
    lookup_valid = 1'b0; lookup_pc = 32'hC0;
    peek("no_lookup", 0, 0, 32'hC4); tick();
    look(32'hFFFF_FFFC);
    peek("wrap", 0, 0, 32'h0); tick();

    // Reset mid-operation together with a taken update
    for (int i = 0; i < 4; i++) begin
      upd(1, 32'h1000 + 32'(i * 4), 0, 1, 32'h2000 + 32'(i * 16), 1); tick();
    end
    upd(0, 32'h0, 0, 0, 32'h0, 0); look(32'h1004);
    peek("pre_rst", 1, 1, 32'h2010);
    upd(1, 32'h1010, 0, 1, 32'h3000, 1); rst = 1'b1;
    peek("in_rst", 0, 0, 32'h1008);
    tick();
    rst = 1'b0; upd(0, 32'h0, 0, 0, 32'h0, 0);
    #1;
    chk("rst_br", 64'(br), 64'd0);
    chk("rst_mis", 64'(mis), 64'd0);
    for (int i = 0; i < 5; i++) begin
      look(32'h1000 + 32'(i * 4));
      peek("post_rst", 0, 0, 32'h1004 + 32'(i * 4));
      tick();
    end

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      lookup_valid = ($urandom_range(0, 7) != 0);
      lookup_pc = rpc();
      upd($urandom_range(0, 2) != 0, rpc(), $urandom_range(0, 5) == 0,
          $urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) upc = lookup_pc;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised branch target buffer with 2-bit saturating direction counters, feeding the pipelined core's IF stage.
- IF looks up pc_IF combinationally and gets a predicted next PC; the MEM stage writes back resolved branch/jump outcomes.
- Replaces the fixed "always sequential, redirect in MEM" policy with configurable depth and tag width, and adds saturating prediction statistics.

Parameters:
ADDR_W, 32, width of PCs and targets.
ENTRIES, 16, number of BTB entries; power of 2, >= 2. INDEX_W = log2(ENTRIES) is derived.
TAG_W, 8, stored partial tag bits; INDEX_W + TAG_W + 2 <= ADDR_W is required.
CNT_W, 16, width of each statistics counter.

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
lookup_valid  in  1  IF lookup request qualifier
lookup_pc  in  ADDR_W  PC being fetched (pc_IF)
pred_hit  out  1  valid entry with matching tag found
pred_taken  out  1  predict redirect
pred_target  out  ADDR_W  predicted next PC
update_valid  in  1  resolved control-flow instruction in MEM this cycle
update_pc  in  ADDR_W  PC of the resolved instruction (pc_MEM)
update_is_jump  in  1  JAL/JALR (unconditional)
update_taken  in  1  actual outcome
update_target  in  ADDR_W  actual target (newJumpAddr_MEM)
update_mispredict  in  1  prediction made in IF was wrong
branch_cnt  out  CNT_W  count of resolved updates
mispredict_cnt  out  CNT_W  count of mispredicts

Behaviour:
- Reset polarity and timing: one clock domain (clk); rst is synchronous, active-high.
- Address fields:
  - index = pc[INDEX_W+1:2].
  - tag = pc[INDEX_W+TAG_W+1:INDEX_W+2].
  - pc[1:0] is ignored.
- Entry state: valid (1), tag (TAG_W), target (ADDR_W), ctr (2). Held in flops, not RAM.
- Lookup is purely combinational, zero latency:
  - hit = lookup_valid & valid[idx] & (tag[idx] == lookup tag).
  - pred_hit = hit.
  - pred_taken = hit & ctr[idx][1].
  - pred_target = target[idx] when pred_taken, else lookup_pc + 4 (wraps modulo 2^ADDR_W).
  - When lookup_valid = 0: pred_hit = 0, pred_taken = 0, pred_target = lookup_pc + 4.
- Update occurs on the clk edge when update_valid = 1.
  - Hit (valid and tag match on update_pc):
    - update_is_jump: ctr <= 11, target <= update_target.
    - Else if update_taken: ctr <= min(ctr+1, 11), target <= update_target.
    - Else: ctr <= max(ctr-1, 00); target unchanged.
  - Miss:
    - If update_taken or update_is_jump: allocate (overwrite unconditionally, no replacement policy). valid <= 1, tag <= update tag, target <= update_target, ctr <= 11 if jump else 10.
    - Not-taken miss: no state change.
- Counter encoding: 00 strongly not-taken, 01 weakly not-taken, 10 weakly taken, 11 strongly taken.
- Simultaneous lookup and update to the same entry: lookup returns the pre-update contents (no bypass). The new contents are visible from the next cycle.
- Statistics:
  - branch_cnt increments by 1 per update_valid.
  - mispredict_cnt increments when update_valid & update_mispredict.
  - Both saturate at all-ones and never wrap.
  - update_mispredict with update_valid = 0 is ignored.
- Reset:
  - On any cycle with rst = 1: all valid bits, ctr, tag and target are cleared to 0, and both stat counters go to 0.
  - An update presented in the same cycle as rst is discarded.
  - Lookup outputs during reset follow the miss rule (pred_target = lookup_pc + 4).
  - Reset mid-run fully empties the table; the first post-reset lookup misses.
- No X propagation: every flop is reset. Outputs are never X after the first reset edge.

Test Plan:
- Cold start: rst for 2 cycles, then lookup 0x0000_0040 -> pred_hit=0, pred_taken=0, pred_target=0x0000_0044; branch_cnt=0, mispredict_cnt=0.
- Allocate and counter walk: update pc=0x40, taken, target=0x100 -> next-cycle lookup 0x40 gives hit=1, taken=1, target=0x100.
  - Two not-taken updates -> hit=1, taken=0, target=0x44.
  - Two more not-taken -> ctr stays 00.
  - Three taken -> ctr 11.
- Jump and aliasing (ENTRIES=16, TAG_W=8):
  - update_is_jump pc=0x80 -> ctr 11.
  - Lookup 0x80 + (16<<2) = 0xC0 (same index, different tag) -> miss, target=0xC4.
  - Taken update at 0xC0 evicts 0x80; lookup 0x80 then misses.
- Same-cycle hazard: update pc=0x40 taken target=0x200 while lookup 0x40 in the same cycle -> that cycle shows old target/miss; the following cycle shows target=0x200.
- Statistics saturation (CNT_W=3): 9 updates with 5 mispredicts -> branch_cnt=7 (saturated), mispredict_cnt=5.
  - Further mispredicts hold mispredict_cnt at 7.
  - update_mispredict with update_valid=0 does not count.
- Reset mid-operation: populate 4 entries, assert rst for 1 cycle together with a taken update -> all lookups miss, counters 0, update not applied.
